zion_riscv_int_ex_arbiter: RTL and testbench

- Shares one combinational integer execution unit between two requesters: req0 is the main issue slot, req1 is a secondary port such as a debug or CSR-address helper.
- Requests are arbitrated round-robin and driven onto the unit's operand/op bus.
- The result is captured into a single-entry response register with a valid/ready handshake.
- Sits between decode/issue and writeback in the execute stage.

---
 rtl/zion_riscv_int_ex_arbiter.sv | 130 +++++++++++++
 tb/tb_zion_riscv_int_ex_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_riscv_int_ex_arbiter.sv
// Round-robin arbiter sharing one combinational integer execution unit between two requesters.
// Latency 1 cycle to rsp_vld; both rdy held low while the response register is occupied and not draining.
// Optional perf counters: define INT_EX_ARB_PERF_CNT_EN.
module zion_riscv_int_ex_arbiter #(
    parameter int RV64  = 1,
    parameter int OP_W  = 24,
    parameter int TAG_W = 4,
    localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,

    input  logic                 req0_vld,
    output logic                 req0_rdy,
    input  logic [OP_W-1:0]      req0_op,
    input  logic [CPU_WIDTH-1:0] req0_s1,
    input  logic [CPU_WIDTH-1:0] req0_s2,
    input  logic [TAG_W-1:0]     req0_tag,

    input  logic                 req1_vld,
    output logic                 req1_rdy,
    input  logic [OP_W-1:0]      req1_op,
    input  logic [CPU_WIDTH-1:0] req1_s1,
    input  logic [CPU_WIDTH-1:0] req1_s2,
    input  logic [TAG_W-1:0]     req1_tag,

    output logic [OP_W-1:0]      ex_op,
    output logic [CPU_WIDTH-1:0] ex_s1,
    output logic [CPU_WIDTH-1:0] ex_s2,
    input  logic [CPU_WIDTH-1:0] ex_rslt,

    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [CPU_WIDTH-1:0] rsp_rslt,
    output logic                 rsp_src,
    output logic [TAG_W-1:0]     rsp_tag
`ifdef INT_EX_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_stall
`endif
);

    logic             ptr;
    logic             slot_free;
    logic             can_grant;
    logic             grant0;
    logic             grant1;
    logic             any_grant;
    logic             grant_idx;
    logic [TAG_W-1:0] grant_tag;

    // A draining response frees the slot in the same cycle, giving back-to-back throughput.
    assign slot_free = !rsp_vld || rsp_rdy;
    assign can_grant = slot_free && !flush;

    assign grant0    = can_grant && req0_vld && (!req1_vld || (ptr == 1'b0));
    assign grant1    = can_grant && req1_vld && (!req0_vld || (ptr == 1'b1));
    assign any_grant = grant0 || grant1;
    assign grant_idx = grant1;

    assign req0_rdy  = grant0;
    assign req1_rdy  = grant1;

    // Idle cycles drive zeros so no unit enable fires and operands do not toggle.
    always_comb begin
        ex_op     = '0;
        ex_s1     = '0;
        ex_s2     = '0;
        grant_tag = '0;
        if (grant0) begin
            ex_op     = req0_op;
            ex_s1     = req0_s1;
            ex_s2     = req0_s2;
            grant_tag = req0_tag;
        end else if (grant1) begin
            ex_op     = req1_op;
            ex_s1     = req1_s1;
            ex_s2     = req1_s2;
            grant_tag = req1_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld  <= 1'b0;
            rsp_rslt <= '0;
            rsp_src  <= 1'b0;
            rsp_tag  <= '0;
        end else if (flush) begin
            rsp_vld  <= 1'b0;
        end else if (any_grant) begin
            rsp_vld  <= 1'b1;
            rsp_rslt <= ex_rslt;
            rsp_src  <= grant_idx;
            rsp_tag  <= grant_tag;
        end else if (rsp_vld && rsp_rdy) begin
            rsp_vld  <= 1'b0;
        end
    end

    // The pointer flips away from every winner, contended or not, so neither side can monopolise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (any_grant) begin
            ptr <= ~grant_idx;
        end
    end

`ifdef INT_EX_ARB_PERF_CNT_EN
    logic stall_cyc;
    assign stall_cyc = (req0_vld && !req0_rdy) || (req1_vld && !req1_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (grant0) perf_grant0 <= perf_grant0 + 32'd1;
            if (grant1) perf_grant1 <= perf_grant1 + 32'd1;
            if (stall_cyc) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_zion_riscv_int_ex_arbiter.sv
// Scoreboard bench for zion_riscv_int_ex_arbiter; a stub ALU stands in for the execution unit.
module tb_zion_riscv_int_ex_arbiter;
    localparam int W     = 64;
    localparam int OP_W  = 24;
    localparam int TAG_W = 4;
    localparam logic [OP_W-1:0] OP_ADD = 24'h000001;
    localparam logic [OP_W-1:0] OP_SUB = 24'h000002;

    typedef struct packed {
        logic [W-1:0]     rslt;
        logic [TAG_W-1:0] tag;
        logic             src;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req0_vld = 1'b0, req1_vld = 1'b0;
    logic             req0_rdy, req1_rdy;
    logic [OP_W-1:0]  req0_op = '0, req1_op = '0;
    logic [W-1:0]     req0_s1 = '0, req0_s2 = '0, req1_s1 = '0, req1_s2 = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [OP_W-1:0]  ex_op;
    logic [W-1:0]     ex_s1, ex_s2, ex_rslt;
    logic             rsp_vld;
    logic             rsp_rdy = 1'b0;
    logic [W-1:0]     rsp_rslt;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;
`ifdef INT_EX_ARB_PERF_CNT_EN
    logic [31:0]      perf_grant0, perf_grant1, perf_stall;
`endif

    int               n_checks = 0;
    int               n_errors = 0;
    exp_t             sb[$];
    logic             last_g0, last_g1;
    logic [OP_W-1:0]  last_ex_op;

    always #5 clk = ~clk;

    assign ex_rslt = ex_op[0] ? ex_s1 + ex_s2 : (ex_op[1] ? ex_s1 - ex_s2 : ex_s1 ^ ex_s2);

    zion_riscv_int_ex_arbiter #(.RV64(1), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_op(req0_op),
        .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_tag(req0_tag),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_op(req1_op),
        .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_tag(req1_tag),
        .ex_op(ex_op), .ex_s1(ex_s1), .ex_s2(ex_s2), .ex_rslt(ex_rslt),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rslt(rsp_rslt),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag)
`ifdef INT_EX_ARB_PERF_CNT_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [W-1:0] model(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        if (op == OP_ADD) return a + b;
        if (op == OP_SUB) return a - b;
        return a ^ b;
    endfunction

    // Samples handshakes mid-cycle, pushes expectations, then steps to just after the next edge.
    task automatic tick();
        @(negedge clk);
        last_g0    = req0_rdy;
        last_g1    = req1_rdy;
        last_ex_op = ex_op;
        if (req0_vld && req0_rdy) sb.push_back('{rslt: model(req0_op, req0_s1, req0_s2), tag: req0_tag, src: 1'b0});
        if (req1_vld && req1_rdy) sb.push_back('{rslt: model(req1_op, req1_s1, req1_s2), tag: req1_tag, src: 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e, output bit got);
        e   = '0;
        got = (sb.size() != 0);
        if (got) e = sb.pop_front();
    endtask

    task automatic do_reset();
        req0_vld = 1'b0; req1_vld = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", rsp_vld); end
        n_checks++; if (rsp_rslt !== '0) begin n_errors++; $display("FAIL reset_rslt: got %0h want 0", rsp_rslt); end
        n_checks++; if (rsp_src !== 1'b0) begin n_errors++; $display("FAIL reset_src: got %b want 0", rsp_src); end
        n_checks++; if (rsp_tag !== '0) begin n_errors++; $display("FAIL reset_tag: got %0h want 0", rsp_tag); end
        n_checks++; if (ex_op !== '0) begin n_errors++; $display("FAIL reset_ex_op: got %0h want 0", ex_op); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        exp_t e; bit got;
        req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'd5; req0_s2 = 64'd3; req0_tag = 4'd2;
        rsp_rdy = 1'b1;
        tick();
        req0_vld = 1'b0;
        n_checks++; if (last_g0 !== 1'b1) begin n_errors++; $display("FAIL single_rdy0: got %b want 1", last_g0); end
        n_checks++; if (rsp_vld !== 1'b1) begin n_errors++; $display("FAIL single_vld: got %b want 1", rsp_vld); end
        n_checks++; if (rsp_rslt !== 64'd8) begin n_errors++; $display("FAIL single_rslt: got %0d want 8", rsp_rslt); end
        n_checks++; if (rsp_tag !== 4'd2) begin n_errors++; $display("FAIL single_tag: got %0d want 2", rsp_tag); end
        n_checks++; if (rsp_src !== 1'b0) begin n_errors++; $display("FAIL single_src: got %b want 0", rsp_src); end
        pop_exp(e, got);
        n_checks++; if (!got) begin n_errors++; $display("FAIL single_sb: no entry, want 1"); end
        tick();
        n_checks++; if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL single_drain_vld: got %b want 0", rsp_vld); end
        n_checks++; if (rsp_rslt !== 64'd8) begin n_errors++; $display("FAIL single_drain_hold: got %0d want 8", rsp_rslt); end
    endtask

    task automatic test_round_robin();
        exp_t e; bit got;
        do_reset();
        rsp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'(10 + i); req0_s2 = 64'(i); req0_tag = 4'(i);
            req1_vld = 1'b1; req1_op = OP_SUB; req1_s1 = 64'd100; req1_s2 = 64'(i); req1_tag = 4'(8 + i);
            tick();
            n_checks++; if (last_g0 !== ((i % 2) == 0)) begin n_errors++; $display("FAIL rr_g0[%0d]: got %b want %b", i, last_g0, (i % 2) == 0); end
            n_checks++; if (last_g1 !== ((i % 2) == 1)) begin n_errors++; $display("FAIL rr_g1[%0d]: got %b want %b", i, last_g1, (i % 2) == 1); end
            n_checks++; if (rsp_vld !== 1'b1) begin n_errors++; $display("FAIL rr_vld[%0d]: got %b want 1", i, rsp_vld); end
            pop_exp(e, got);
            n_checks++; if (!got) begin n_errors++; $display("FAIL rr_sb[%0d]: no entry, want 1", i); end
            n_checks++; if (rsp_rslt !== e.rslt) begin n_errors++; $display("FAIL rr_rslt[%0d]: got %0h want %0h", i, rsp_rslt, e.rslt); end
            n_checks++; if (rsp_src !== 1'(i % 2)) begin n_errors++; $display("FAIL rr_src[%0d]: got %b want %0d", i, rsp_src, i % 2); end
            n_checks++; if (rsp_tag !== e.tag) begin n_errors++; $display("FAIL rr_tag[%0d]: got %0h want %0h", i, rsp_tag, e.tag); end
        end
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        exp_t e; exp_t e2; bit got;
        req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'd7; req0_s2 = 64'd9; req0_tag = 4'd5;
        rsp_rdy = 1'b1;
        tick();
        pop_exp(e, got);
        n_checks++; if (!got || rsp_rslt !== 64'd16) begin n_errors++; $display("FAIL stall_setup: got %0d want 16", rsp_rslt); end
        req0_vld = 1'b0; rsp_rdy = 1'b0;
        req1_vld = 1'b1; req1_op = OP_SUB; req1_s1 = 64'd50; req1_s2 = 64'd8; req1_tag = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (last_g1 !== 1'b0) begin n_errors++; $display("FAIL stall_rdy1[%0d]: got %b want 0", i, last_g1); end
            n_checks++; if (last_ex_op !== '0) begin n_errors++; $display("FAIL stall_ex_op[%0d]: got %0h want 0", i, last_ex_op); end
            n_checks++; if (rsp_vld !== 1'b1) begin n_errors++; $display("FAIL stall_vld[%0d]: got %b want 1", i, rsp_vld); end
            n_checks++; if (rsp_rslt !== e.rslt || rsp_tag !== e.tag || rsp_src !== e.src) begin
                n_errors++; $display("FAIL stall_hold[%0d]: got %0h/%0h/%b want %0h/%0h/%b", i, rsp_rslt, rsp_tag, rsp_src, e.rslt, e.tag, e.src);
            end
        end
        rsp_rdy = 1'b1;
        tick();
        req1_vld = 1'b0;
        n_checks++; if (last_g1 !== 1'b1) begin n_errors++; $display("FAIL stall_release_rdy1: got %b want 1", last_g1); end
        pop_exp(e2, got);
        n_checks++; if (!got || rsp_rslt !== 64'd42) begin n_errors++; $display("FAIL stall_release_rslt: got %0d want 42", rsp_rslt); end
        n_checks++; if (rsp_src !== 1'b1 || rsp_tag !== 4'd9) begin n_errors++; $display("FAIL stall_release_id: got %b/%0d want 1/9", rsp_src, rsp_tag); end
        tick();
        n_checks++; if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL stall_drain: got %b want 0", rsp_vld); end
    endtask

    task automatic test_flush();
        exp_t e; bit got;
        rsp_rdy = 1'b1;
        req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'd1; req0_s2 = 64'd2; req0_tag = 4'd3;
        tick();
        pop_exp(e, got);
        n_checks++; if (!got || rsp_vld !== 1'b1 || rsp_rslt !== 64'd3) begin n_errors++; $display("FAIL flush_setup: got vld %b rslt %0d want 1/3", rsp_vld, rsp_rslt); end
        flush = 1'b1;
        req0_s1 = 64'd20;
        tick();
        flush = 1'b0;
        n_checks++; if (last_g0 !== 1'b0 || last_g1 !== 1'b0) begin n_errors++; $display("FAIL flush_no_grant: got %b%b want 00", last_g1, last_g0); end
        n_checks++; if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL flush_vld: got %b want 0", rsp_vld); end
        req1_vld = 1'b1; req1_op = OP_ADD; req1_s1 = 64'd30; req1_s2 = 64'd4; req1_tag = 4'd6;
        tick();
        req0_vld = 1'b0; req1_vld = 1'b0;
        n_checks++; if (last_g1 !== 1'b1 || last_g0 !== 1'b0) begin n_errors++; $display("FAIL flush_ptr: got %b%b want 10", last_g1, last_g0); end
        pop_exp(e, got);
        n_checks++; if (!got || rsp_rslt !== 64'd34 || rsp_src !== 1'b1) begin n_errors++; $display("FAIL flush_after_rslt: got %0d/%b want 34/1", rsp_rslt, rsp_src); end
        tick();
    endtask

    task automatic test_async_reset();
        exp_t e; bit got;
        rsp_rdy = 1'b1;
        req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'd11; req0_s2 = 64'd11; req0_tag = 4'd1;
        tick();
        req0_vld = 1'b0;
        pop_exp(e, got);
        n_checks++; if (!got || rsp_vld !== 1'b1) begin n_errors++; $display("FAIL areset_setup: got vld %b want 1", rsp_vld); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL areset_vld: got %b want 0", rsp_vld); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        req0_vld = 1'b1; req0_op = OP_SUB; req0_s1 = 64'd9; req0_s2 = 64'd4; req0_tag = 4'd7;
        req1_vld = 1'b1; req1_op = OP_ADD; req1_s1 = 64'd1; req1_s2 = 64'd1; req1_tag = 4'd8;
        tick();
        req0_vld = 1'b0; req1_vld = 1'b0;
        n_checks++; if (last_g0 !== 1'b1 || last_g1 !== 1'b0) begin n_errors++; $display("FAIL areset_ptr: got %b%b want 01", last_g1, last_g0); end
        pop_exp(e, got);
        n_checks++; if (!got || rsp_rslt !== 64'd5 || rsp_tag !== 4'd7) begin n_errors++; $display("FAIL areset_rslt: got %0d/%0d want 5/7", rsp_rslt, rsp_tag); end
        tick();
    endtask

`ifdef INT_EX_ARB_PERF_CNT_EN
    task automatic test_perf();
        exp_t e; bit got;
        do_reset();
        n_checks++; if (perf_grant0 !== 32'd0 || perf_stall !== 32'd0) begin n_errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_grant0, perf_stall); end
        rsp_rdy = 1'b1;
        req0_vld = 1'b1; req0_op = OP_ADD; req0_s1 = 64'd2; req0_s2 = 64'd2; req0_tag = 4'd0;
        req1_vld = 1'b1; req1_op = OP_ADD; req1_s1 = 64'd3; req1_s2 = 64'd3; req1_tag = 4'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pop_exp(e, got);
        end
        req0_vld = 1'b0; req1_vld = 1'b0;
        n_checks++; if (perf_grant0 !== 32'd5) begin n_errors++; $display("FAIL perf_grant0: got %0d want 5", perf_grant0); end
        n_checks++; if (perf_grant1 !== 32'd5) begin n_errors++; $display("FAIL perf_grant1: got %0d want 5", perf_grant1); end
        n_checks++; if (perf_stall !== 32'd10) begin n_errors++; $display("FAIL perf_stall: got %0d want 10", perf_stall); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_flush();
        test_async_reset();
`ifdef INT_EX_ARB_PERF_CNT_EN
        test_perf();
`endif
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
